ws2812_strip_sequencer: RTL and testbench

Frame sequencer for a WS2812 chain.
- On `start`, walks pixel RAM from address 0 to NUM_LEDS-1.
- Loads each 24-bit word into BitController via its `reset`/`indata` load interface.
- Waits for the controller's `done`, then enforces the latch (reset-low) interval before reporting frame completion.
- Sits between the frame-buffer RAM and BitController; top-level logic only issues `start` and watches `busy`.

---
 rtl/ws2812_pkg.sv | 20 ++
 rtl/ws2812_strip_sequencer_if.sv | 26 ++
 rtl/ws2812_latch_timer.sv | 26 ++
 rtl/ws2812_strip_sequencer.sv | 100 ++++++++++
 tb/tb_ws2812_strip_sequencer.sv | 325 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ws2812_pkg.sv
// Shared WS2812 types and timing helpers, used by the strip sequencer and BitController.
package ws2812_pkg;

    localparam int PIXEL_W = 24;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        GUARD,
        SHIFT,
        LATCH
    } seq_state_t;

    // F_CLK is truncated to whole MHz before scaling, all in 32-bit integer.
    function automatic int us_to_cycles(input int f_clk, input int us);
        return (f_clk / 1_000_000) * us;
    endfunction

endpackage

// File: rtl/ws2812_strip_sequencer_if.sv
// Bus between the frame sequencer, the pixel RAM and BitController.
interface ws2812_strip_sequencer_if #(
    parameter int AW = 3
);
    import ws2812_pkg::*;

    logic               start;
    logic               busy;
    logic               frame_done;
    logic [AW-1:0]      pix_addr;
    logic [PIXEL_W-1:0] pix_data;
    logic [PIXEL_W-1:0] bc_data;
    logic               bc_load;
    logic               bc_done;

    modport master (
        input  start, pix_data, bc_done,
        output busy, frame_done, pix_addr, bc_data, bc_load
    );

    modport slave (
        output start, pix_data, bc_done,
        input  busy, frame_done, pix_addr, bc_data, bc_load
    );

endinterface

// File: rtl/ws2812_latch_timer.sv
// Cycle counter with load, enable and a terminal pulse after TERM+1 enabled cycles.
module ws2812_latch_timer #(
    parameter int CW   = 12,
    parameter int TERM = 0
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic en,
    output logic tc
);
    logic [CW-1:0] cnt;

    assign tc = en && (cnt == CW'(TERM));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (load || tc) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/ws2812_strip_sequencer.sv
// WS2812 frame sequencer: streams pixel RAM into BitController, then holds the latch gap.
// Optional continuous refresh with `define WS2812_AUTO_REFRESH_EN.
module ws2812_strip_sequencer
    import ws2812_pkg::*;
#(
    parameter int F_CLK    = 50_000_000,
    parameter int NUM_LEDS = 8,
    parameter int LATCH_US = 80,
    localparam int AW      = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
    input logic                      clk,
    input logic                      reset,
    ws2812_strip_sequencer_if.master bus
);
    localparam int LATCH_CYC  = us_to_cycles(F_CLK, LATCH_US);
    localparam int LCW        = (LATCH_CYC > 0) ? $clog2(LATCH_CYC + 1) : 1;
    // The SHIFT cycle that sees the final bc_done is the first cycle of the latch gap.
    localparam int LATCH_TERM = (LATCH_CYC > 2) ? LATCH_CYC - 2 : 0;

    seq_state_t state;
    logic       last_pix;
    logic       latch_load;
    logic       latch_tc;

    assign last_pix   = (bus.pix_addr == AW'(NUM_LEDS - 1));
    assign latch_load = (state == SHIFT) && bus.bc_done && last_pix;

    ws2812_latch_timer #(
        .CW   (LCW),
        .TERM (LATCH_TERM)
    ) u_latch_timer (
        .clk   (clk),
        .reset (reset),
        .load  (latch_load),
        .en    (state == LATCH),
        .tc    (latch_tc)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            bus.busy       <= 1'b0;
            bus.frame_done <= 1'b0;
            bus.bc_load    <= 1'b0;
            bus.bc_data    <= '0;
            bus.pix_addr   <= '0;
        end else begin
            bus.frame_done <= 1'b0;
            bus.bc_load    <= 1'b0;
            case (state)
                IDLE: begin
`ifdef WS2812_AUTO_REFRESH_EN
                    state        <= FETCH;
                    bus.busy     <= 1'b1;
                    bus.pix_addr <= '0;
`else
                    // A start coinciding with frame_done belongs to the old frame.
                    if (bus.start && !bus.frame_done) begin
                        state        <= FETCH;
                        bus.busy     <= 1'b1;
                        bus.pix_addr <= '0;
                    end
`endif
                end
                FETCH: state <= LOAD;
                LOAD: begin
                    bus.bc_data <= bus.pix_data;
                    bus.bc_load <= 1'b1;
                    state       <= GUARD;
                end
                // bc_done may still be high from the previous word here.
                GUARD: state <= SHIFT;
                SHIFT: begin
                    if (bus.bc_done) begin
                        if (last_pix) begin
                            state <= LATCH;
                        end else begin
                            bus.pix_addr <= bus.pix_addr + 1'b1;
                            state        <= FETCH;
                        end
                    end
                end
                LATCH: begin
                    if (latch_tc) begin
                        bus.frame_done <= 1'b1;
`ifdef WS2812_AUTO_REFRESH_EN
                        bus.pix_addr   <= '0;
                        state          <= FETCH;
`else
                        bus.busy       <= 1'b0;
                        state          <= IDLE;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ws2812_strip_sequencer.sv
// Self-checking bench for ws2812_strip_sequencer: a 3-pixel and a 1-pixel strip
// against a RAM/BitController model and cycle arithmetic taken from the frame rules.
module tb_ws2812_strip_sequencer;
    import ws2812_pkg::*;

    localparam int F_CLK = 50_000_000;
    localparam int LC3   = (F_CLK / 1_000_000) * 80;
    localparam int LC1   = (F_CLK / 1_000_000) * 10;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ws2812_strip_sequencer_if #(.AW(2)) bus3 ();
    ws2812_strip_sequencer_if #(.AW(1)) bus1 ();

    ws2812_strip_sequencer #(.F_CLK(F_CLK), .NUM_LEDS(3), .LATCH_US(80)) dut3 (
        .clk(clk), .reset(reset), .bus(bus3)
    );
    ws2812_strip_sequencer #(.F_CLK(F_CLK), .NUM_LEDS(1), .LATCH_US(10)) dut1 (
        .clk(clk), .reset(reset), .bus(bus1)
    );

    logic [23:0] ram3 [4];
    logic [1:0]  addr3_prev = '0;
    logic [23:0] prev_bc3 = '0;
    int          word3 = 20, cnt3 = 0, stab_err3 = 0;
    bit          hold3 = 0;
    logic [23:0] ld_data3 [$];
    int          ld_cyc3 [$], ld_addr3 [$], done_cyc3 [$], fd_cyc3 [$];

    logic [23:0] ram1 [2];
    logic [0:0]  addr1_prev = '0;
    int          word1 = 20, cnt1 = 0, busy_cnt1 = 0, ld_cnt1 = 0, done_cyc1 = 0, fd_cyc1 = 0;
    logic [23:0] ld_data1 = '0;

    // Synchronous RAM (one cycle of read latency) plus BitController: done rises word cycles after a load.
    always @(negedge clk) begin
        bus3.pix_data = ram3[addr3_prev];
        addr3_prev    = bus3.pix_addr;
        if (!reset && (bus3.bc_data !== prev_bc3) && !bus3.bc_load) stab_err3++;
        prev_bc3 = bus3.bc_data;
        if (reset) begin
            cnt3 = 0;
            bus3.bc_done = hold3;
        end else if (bus3.bc_load) begin
            ld_data3.push_back(bus3.bc_data);
            ld_cyc3.push_back(cyc);
            ld_addr3.push_back(int'(bus3.pix_addr));
            cnt3 = hold3 ? 0 : word3;
            bus3.bc_done = hold3;
        end else if (hold3) begin
            bus3.bc_done = 1'b1;
        end else if (cnt3 > 0) begin
            cnt3--;
            if (cnt3 == 0) begin
                bus3.bc_done = 1'b1;
                done_cyc3.push_back(cyc);
            end
        end
        if (bus3.frame_done) fd_cyc3.push_back(cyc);
    end

    always @(negedge clk) begin
        bus1.pix_data = ram1[addr1_prev];
        addr1_prev    = bus1.pix_addr;
        if (bus1.busy) busy_cnt1++;
        if (reset) begin
            cnt1 = 0;
            bus1.bc_done = 1'b0;
        end else if (bus1.bc_load) begin
            ld_cnt1++;
            ld_data1 = bus1.bc_data;
            cnt1 = word1;
            bus1.bc_done = 1'b0;
        end else if (cnt1 > 0) begin
            cnt1--;
            if (cnt1 == 0) begin
                bus1.bc_done = 1'b1;
                done_cyc1 = cyc;
            end
        end
        if (bus1.frame_done) fd_cyc1 = cyc;
    end

    task automatic clear3();
        ld_data3.delete(); ld_cyc3.delete(); ld_addr3.delete();
        done_cyc3.delete(); fd_cyc3.delete();
        stab_err3 = 0;
    endtask

    task automatic wait_fd3(input int budget, output bit ok);
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (bus3.frame_done) begin
                ok = 1;
                break;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus3.start = 1'b0;
        bus1.start = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        vectors++; if (bus3.busy !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_busy: got %b expected 0", bus3.busy); end
        vectors++; if (bus3.frame_done !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_frame_done: got %b expected 0", bus3.frame_done); end
        vectors++; if (bus3.bc_load !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_bc_load: got %b expected 0", bus3.bc_load); end
        vectors++; if (bus3.bc_data !== 24'h0) begin miscompares++; $display("[TB] FAIL reset_bc_data: got %h expected 000000", bus3.bc_data); end
        vectors++; if (bus3.pix_addr !== 2'd0) begin miscompares++; $display("[TB] FAIL reset_pix_addr: got %0d expected 0", bus3.pix_addr); end
        vectors++; if (bus1.busy !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_busy1: got %b expected 0", bus1.busy); end
        @(negedge clk);
        reset = 1'b0;
    endtask

`ifdef WS2812_AUTO_REFRESH_EN
    task automatic test_auto_refresh();
        int frames, idle_cycles, seen_busy;
        clear3();
        for (int i = 0; i < 3; i++) ram3[i] = 24'($urandom);
        word3 = int'($urandom_range(10, 40));
        frames = 0; idle_cycles = 0; seen_busy = 0;
        for (int i = 0; i < 20000 && frames < 3; i++) begin
            @(negedge clk);
            if (bus3.busy) seen_busy = 1;
            else if (seen_busy != 0) idle_cycles++;
            if (bus3.frame_done) frames++;
        end
        #1;
        vectors++; if (frames !== 3) begin miscompares++; $display("[TB] FAIL auto_frames: got %0d expected 3", frames); end
        vectors++; if (idle_cycles !== 0) begin miscompares++; $display("[TB] FAIL auto_no_idle: got %0d idle cycles expected 0", idle_cycles); end
        for (int i = 0; i < 9; i++) begin
            int a;
            logic [23:0] d;
            a = (i < ld_addr3.size()) ? ld_addr3[i] : -1;
            d = (i < ld_data3.size()) ? ld_data3[i] : 24'hxxxxxx;
            vectors++; if (a !== i % 3) begin miscompares++; $display("[TB] FAIL auto_addr[%0d]: got %0d expected %0d", i, a, i % 3); end
            vectors++; if (d !== ram3[i % 3]) begin miscompares++; $display("[TB] FAIL auto_data[%0d]: got %h expected %h", i, d, ram3[i % 3]); end
        end
        if (fd_cyc3.size() >= 1 && ld_cyc3.size() >= 4) begin
            vectors++; if (ld_cyc3[3] !== fd_cyc3[0] + 2) begin miscompares++; $display("[TB] FAIL auto_restart_gap: got %0d expected %0d", ld_cyc3[3], fd_cyc3[0] + 2); end
        end
    endtask
`else
    task automatic test_frame_order();
        bit ok;
        int c0;
        clear3();
        ram3[0] = 24'h00FF00; ram3[1] = 24'h123456; ram3[2] = 24'hABCDEF;
        word3 = 1200;
        hold3 = 0;
        @(negedge clk);
        bus3.start = 1'b1; c0 = cyc;
        @(negedge clk);
        bus3.start = 1'b0;
        wait_fd3(10000, ok);
        vectors++; if (ok !== 1'b1) begin miscompares++; $display("[TB] FAIL order_timeout: got no frame_done expected one"); end
        vectors++; if (bus3.busy !== 1'b0) begin miscompares++; $display("[TB] FAIL order_busy_at_done: got %b expected 0", bus3.busy); end
        vectors++; if (ld_data3.size() !== 3) begin miscompares++; $display("[TB] FAIL order_load_count: got %0d expected 3", ld_data3.size()); end
        for (int i = 0; i < 3; i++) begin
            logic [23:0] d;
            d = (i < ld_data3.size()) ? ld_data3[i] : 24'hxxxxxx;
            vectors++; if (d !== ram3[i]) begin miscompares++; $display("[TB] FAIL order_data[%0d]: got %h expected %h", i, d, ram3[i]); end
        end
        if (ld_cyc3.size() == 3 && done_cyc3.size() == 3 && fd_cyc3.size() == 1) begin
            vectors++; if (ld_cyc3[0] !== c0 + 3) begin miscompares++; $display("[TB] FAIL order_first_load: got %0d expected %0d", ld_cyc3[0], c0 + 3); end
            for (int i = 0; i < 2; i++) begin
                vectors++; if (ld_cyc3[i+1] - done_cyc3[i] !== 3) begin miscompares++; $display("[TB] FAIL order_gap[%0d]: got %0d expected 3", i, ld_cyc3[i+1] - done_cyc3[i]); end
            end
            vectors++; if (fd_cyc3[0] - done_cyc3[2] !== LC3) begin miscompares++; $display("[TB] FAIL order_latch: got %0d expected %0d", fd_cyc3[0] - done_cyc3[2], LC3); end
        end
        vectors++; if (stab_err3 !== 0) begin miscompares++; $display("[TB] FAIL order_bc_data_stable: got %0d changes expected 0", stab_err3); end
    endtask

    task automatic test_start_while_busy();
        bit ok;
        int f;
        logic busy_a, busy_b;
        clear3();
        for (int i = 0; i < 3; i++) ram3[i] = 24'($urandom);
        word3 = int'($urandom_range(10, 40));
        @(negedge clk);
        bus3.start = 1'b1;
        wait_fd3(6000, ok);
        f = cyc;
        vectors++; if (ok !== 1'b1) begin miscompares++; $display("[TB] FAIL busy_start_timeout: got no frame_done expected one"); end
        vectors++; if (ld_data3.size() !== 3) begin miscompares++; $display("[TB] FAIL busy_start_loads: got %0d expected 3", ld_data3.size()); end
        @(negedge clk);
        busy_a = bus3.busy;
        @(negedge clk);
        busy_b = bus3.busy;
        bus3.start = 1'b0;
        vectors++; if (busy_a !== 1'b0) begin miscompares++; $display("[TB] FAIL start_with_done: got busy %b expected 0", busy_a); end
        vectors++; if (busy_b !== 1'b1) begin miscompares++; $display("[TB] FAIL start_after_done: got busy %b expected 1", busy_b); end
        wait_fd3(6000, ok);
        vectors++; if (fd_cyc3.size() !== 2) begin miscompares++; $display("[TB] FAIL busy_start_frames: got %0d expected 2", fd_cyc3.size()); end
        vectors++; if (ld_data3.size() !== 6) begin miscompares++; $display("[TB] FAIL busy_start_total_loads: got %0d expected 6", ld_data3.size()); end
        if (ld_cyc3.size() >= 4) begin
            vectors++; if (ld_cyc3[3] !== f + 4) begin miscompares++; $display("[TB] FAIL second_frame_start: got %0d expected %0d", ld_cyc3[3], f + 4); end
        end
        for (int i = 3; i < 6; i++) begin
            logic [23:0] d;
            d = (i < ld_data3.size()) ? ld_data3[i] : 24'hxxxxxx;
            vectors++; if (d !== ram3[i - 3]) begin miscompares++; $display("[TB] FAIL second_frame_data[%0d]: got %h expected %h", i - 3, d, ram3[i - 3]); end
        end
    endtask

    task automatic test_done_held();
        bit ok;
        clear3();
        for (int i = 0; i < 3; i++) ram3[i] = 24'($urandom);
        hold3 = 1;
        @(negedge clk);
        bus3.start = 1'b1;
        @(negedge clk);
        bus3.start = 1'b0;
        wait_fd3(6000, ok);
        hold3 = 0;
        vectors++; if (ok !== 1'b1) begin miscompares++; $display("[TB] FAIL held_timeout: got no frame_done expected one"); end
        vectors++; if (ld_cyc3.size() !== 3) begin miscompares++; $display("[TB] FAIL held_loads: got %0d expected 3", ld_cyc3.size()); end
        if (ld_cyc3.size() == 3 && fd_cyc3.size() == 1) begin
            for (int i = 0; i < 3; i++) begin
                vectors++; if (ld_addr3[i] !== i) begin miscompares++; $display("[TB] FAIL held_addr[%0d]: got %0d expected %0d", i, ld_addr3[i], i); end
                vectors++; if (ld_data3[i] !== ram3[i]) begin miscompares++; $display("[TB] FAIL held_data[%0d]: got %h expected %h", i, ld_data3[i], ram3[i]); end
            end
            for (int i = 0; i < 2; i++) begin
                vectors++; if (ld_cyc3[i+1] - ld_cyc3[i] !== 4) begin miscompares++; $display("[TB] FAIL held_spacing[%0d]: got %0d expected 4", i, ld_cyc3[i+1] - ld_cyc3[i]); end
            end
            vectors++; if (fd_cyc3[0] - ld_cyc3[2] !== LC3 + 1) begin miscompares++; $display("[TB] FAIL held_latch: got %0d expected %0d", fd_cyc3[0] - ld_cyc3[2], LC3 + 1); end
        end
    endtask

    task automatic test_reset_mid_frame();
        bit ok;
        int n;
        clear3();
        for (int i = 0; i < 3; i++) ram3[i] = 24'($urandom);
        word3 = int'($urandom_range(30, 60));
        @(negedge clk);
        bus3.start = 1'b1;
        @(negedge clk);
        bus3.start = 1'b0;
        for (int i = 0; i < 500 && ld_cyc3.size() < 2; i++) @(negedge clk);
        repeat (int'($urandom_range(3, 20))) @(negedge clk);
        reset = 1'b1;
        #1;
        vectors++; if (bus3.busy !== 1'b0) begin miscompares++; $display("[TB] FAIL abort_busy: got %b expected 0", bus3.busy); end
        vectors++; if (bus3.bc_load !== 1'b0) begin miscompares++; $display("[TB] FAIL abort_bc_load: got %b expected 0", bus3.bc_load); end
        vectors++; if (bus3.pix_addr !== 2'd0) begin miscompares++; $display("[TB] FAIL abort_pix_addr: got %0d expected 0", bus3.pix_addr); end
        n = ld_cyc3.size();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        #1;
        vectors++; if (ld_cyc3.size() !== n) begin miscompares++; $display("[TB] FAIL abort_no_load: got %0d loads expected %0d", ld_cyc3.size(), n); end
        clear3();
        @(negedge clk);
        bus3.start = 1'b1;
        @(negedge clk);
        bus3.start = 1'b0;
        wait_fd3(6000, ok);
        vectors++; if (ok !== 1'b1) begin miscompares++; $display("[TB] FAIL fresh_timeout: got no frame_done expected one"); end
        for (int i = 0; i < 3; i++) begin
            int a;
            logic [23:0] d;
            a = (i < ld_addr3.size()) ? ld_addr3[i] : -1;
            d = (i < ld_data3.size()) ? ld_data3[i] : 24'hxxxxxx;
            vectors++; if (a !== i) begin miscompares++; $display("[TB] FAIL fresh_addr[%0d]: got %0d expected %0d", i, a, i); end
            vectors++; if (d !== ram3[i]) begin miscompares++; $display("[TB] FAIL fresh_data[%0d]: got %h expected %h", i, d, ram3[i]); end
        end
    endtask

    task automatic test_single_led();
        bit ok;
        ram1[0] = 24'($urandom);
        ram1[1] = 24'($urandom);
        word1 = int'($urandom_range(20, 50));
        ld_cnt1 = 0;
        @(negedge clk);
        bus1.start = 1'b1;
        busy_cnt1 = 0;
        @(negedge clk);
        bus1.start = 1'b0;
        ok = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (bus1.frame_done) begin
                ok = 1;
                break;
            end
        end
        #1;
        vectors++; if (ok !== 1'b1) begin miscompares++; $display("[TB] FAIL single_timeout: got no frame_done expected one"); end
        vectors++; if (ld_cnt1 !== 1) begin miscompares++; $display("[TB] FAIL single_loads: got %0d expected 1", ld_cnt1); end
        vectors++; if (ld_data1 !== ram1[0]) begin miscompares++; $display("[TB] FAIL single_data: got %h expected %h", ld_data1, ram1[0]); end
        vectors++; if (fd_cyc1 - done_cyc1 !== LC1) begin miscompares++; $display("[TB] FAIL single_latch: got %0d expected %0d", fd_cyc1 - done_cyc1, LC1); end
        vectors++; if (busy_cnt1 !== word1 + LC1 + 2) begin miscompares++; $display("[TB] FAIL single_busy_len: got %0d expected %0d", busy_cnt1, word1 + LC1 + 2); end
    endtask
`endif

    initial begin
        test_reset();
`ifdef WS2812_AUTO_REFRESH_EN
        test_auto_refresh();
`else
        test_frame_order();
        test_start_while_busy();
        test_done_held();
        test_reset_mid_frame();
        test_single_led();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
